// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        LAP,
        PAUSED,
        CLEAR
    } sw_state_t;

    localparam int unsigned TICK_DIV_DEFAULT = 10;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge press detector; history resets high so a button held through reset is not a press.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_c_o
);

    logic hist_q;
    logic hist_d;

    assign hist_d = btn_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign press_c_o = btn_i & ~hist_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: drives enable/clear/load strobes of a BCD counter chain from two buttons.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_start_stop,
    input  logic btn_lap_reset,
    input  logic cnt_carry,
    output logic cnt_en,
    output logic cnt_reset,
    output logic cnt_load,
    output logic running,
    output logic lap_active,
    output logic overflow
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    sw_state_t     state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          ovf_q, ovf_d;
    logic          ss_press_c, lr_press_c;
    logic          active_c;

    btn_edge u_ss_edge (
        .clk       (clk),
        .reset     (reset),
        .btn_i     (btn_start_stop),
        .press_c_o (ss_press_c)
    );

    btn_edge u_lr_edge (
        .clk       (clk),
        .reset     (reset),
        .btn_i     (btn_lap_reset),
        .press_c_o (lr_press_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            presc_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next state, prescaler and Moore output decode; start_stop wins over lap_reset.
    always_comb begin
        state_d    = state_q;
        presc_d    = '0;
        ovf_d      = ovf_q;
        active_c   = (state_q == RUN) || (state_q == LAP);
        cnt_en     = 1'b0;
        cnt_reset  = reset || (state_q == CLEAR);
        cnt_load   = reset || (state_q != LAP);
        running    = ~reset && active_c;
        lap_active = ~reset && (state_q == LAP);

        if (~reset && active_c && (presc_q == PRESC_MAX)) begin
            cnt_en = 1'b1;
        end

        unique case (state_q)
            RUN, LAP: presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
            PAUSED:   presc_d = presc_q;
            default:  presc_d = '0;
        endcase

        unique case (state_q)
            IDLE: begin
                if (ss_press_c)      state_d = RUN;
                else if (lr_press_c) state_d = CLEAR;
            end
            RUN: begin
                if (ss_press_c)      state_d = PAUSED;
                else if (lr_press_c) state_d = LAP;
            end
            LAP: begin
                if (ss_press_c)      state_d = PAUSED;
                else if (lr_press_c) state_d = RUN;
            end
            PAUSED: begin
                if (ss_press_c)      state_d = RUN;
                else if (lr_press_c) state_d = CLEAR;
            end
            default: state_d = IDLE;
        endcase

        if (state_q == CLEAR) begin
            ovf_d = 1'b0;
        end else if (cnt_en && cnt_carry) begin
            ovf_d = 1'b1;
        end
    end

    assign overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus randomized buttons vs. a mode model.
module tb_stopwatch_ctrl;

    localparam int TD = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSED = 3, M_CLEAR = 4;

    logic clk;
    logic reset;
    logic btn_ss;
    logic btn_lr;
    logic cnt_carry;
    logic cnt_en, cnt_reset, cnt_load, running, lap_active, overflow;

    int n_pass = 0;
    int n_tot  = 0;

    // Behavioural model state
    int m_mode;
    int m_phase;
    int m_cnt;
    bit m_ovf;
    bit m_hss;
    bit m_hlr;

    stopwatch_ctrl #(.TICK_DIV(TD)) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_start_stop (btn_ss),
        .btn_lap_reset  (btn_lr),
        .cnt_carry      (cnt_carry),
        .cnt_en         (cnt_en),
        .cnt_reset      (cnt_reset),
        .cnt_load       (cnt_load),
        .running        (running),
        .lap_active     (lap_active),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit counting();
        return (m_mode == M_RUN) || (m_mode == M_LAP);
    endfunction

    function automatic bit exp_en();
        return !reset && counting() && (m_phase == TD - 1);
    endfunction

    function automatic bit pss();
        return btn_ss && !m_hss;
    endfunction

    function automatic bit plr();
        return btn_lr && !m_hlr;
    endfunction

    function automatic int next_mode();
        if (m_mode == M_CLEAR) return M_IDLE;
        if (pss()) return (m_mode == M_IDLE || m_mode == M_PAUSED) ? M_RUN : M_PAUSED;
        if (plr()) begin
            case (m_mode)
                M_RUN:   return M_LAP;
                M_LAP:   return M_RUN;
                default: return M_CLEAR;
            endcase
        end
        return m_mode;
    endfunction

    function automatic int next_phase();
        if (counting()) return (m_phase + 1) % TD;
        if (m_mode == M_PAUSED) return m_phase;
        return 0;
    endfunction

    function automatic bit next_ovf();
        if (m_mode == M_CLEAR) return 1'b0;
        return m_ovf || (exp_en() && cnt_carry);
    endfunction

    function automatic int next_cnt();
        if (m_mode == M_CLEAR) return 0;
        return exp_en() ? (m_cnt + 1) % 1000 : m_cnt;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_mode  <= M_IDLE;
            m_phase <= 0;
            m_cnt   <= 0;
            m_ovf   <= 1'b0;
            m_hss   <= 1'b1;
            m_hlr   <= 1'b1;
        end else begin
            m_mode  <= next_mode();
            m_phase <= next_phase();
            m_cnt   <= next_cnt();
            m_ovf   <= next_ovf();
            m_hss   <= btn_ss;
            m_hlr   <= btn_lr;
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Advance one clock and compare every output against the model on the falling edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        chk("m_cnt_en",     cnt_en,     exp_en());
        chk("m_cnt_reset",  cnt_reset,  reset || (m_mode == M_CLEAR));
        chk("m_cnt_load",   cnt_load,   reset || (m_mode != M_LAP));
        chk("m_running",    running,    !reset && counting());
        chk("m_lap_active", lap_active, !reset && (m_mode == M_LAP));
        chk("m_overflow",   overflow,   m_ovf);
    endtask

    initial begin
        int t;
        int w;
        reset = 1'b1; btn_ss = 1'b1; btn_lr = 1'b0; cnt_carry = 1'b0;

        // Reset held with start_stop down; release must not look like a press
        cycle();
        cycle();
        chk("rst_cnt_reset", cnt_reset, 1'b1);
        chk("rst_cnt_load",  cnt_load,  1'b1);
        chk("rst_running",   running,   1'b0);
        chk("rst_overflow",  overflow,  1'b0);
        reset = 1'b0;
        repeat (3) begin
            cycle();
            chk("idle_running", running,   1'b0);
            chk("idle_creset",  cnt_reset, 1'b0);
            chk("idle_en",      cnt_en,    1'b0);
        end
        btn_ss = 1'b0;
        cycle();

        // Start: ticks in cycles 3, 7, 11 ... after RUN entry
        btn_ss = 1'b1;
        cycle();
        btn_ss = 1'b0;
        chk("start_running", running, 1'b1);
        t = 0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) cycle();
            chk("tick_phase", cnt_en, (k % 4) == 3);
            if (cnt_en) t++;
        end
        chk_int("ticks_40", t, 10);
        cycle();
        chk_int("model_cnt", m_cnt, 10);

        // Pause at prescaler 1, hold, resume
        cycle();
        btn_ss = 1'b1;
        cycle();
        btn_ss = 1'b0;
        chk("paused_running", running, 1'b0);
        repeat (20) begin
            cycle();
            chk("paused_no_tick", cnt_en, 1'b0);
        end
        btn_ss = 1'b1;
        cycle();
        btn_ss = 1'b0;
        chk("resume_running", running, 1'b1);
        chk("resume_no_tick", cnt_en, 1'b0);
        cycle();
        chk("resume_tick", cnt_en, 1'b1);

        // Lap freeze
        btn_lr = 1'b1;
        cycle();
        btn_lr = 1'b0;
        chk("lap_active", lap_active, 1'b1);
        chk("lap_load",   cnt_load,   1'b0);
        t = 0;
        repeat (8) begin
            cycle();
            chk("lap_load_hold", cnt_load, 1'b0);
            if (cnt_en) t++;
        end
        chk_int("lap_ticks", t, 2);
        btn_lr = 1'b1;
        cycle();
        btn_lr = 1'b0;
        chk("unlap_load", cnt_load,   1'b1);
        chk("unlap_lap",  lap_active, 1'b0);

        // Carry without a tick is ignored; carry with a tick sets overflow
        cnt_carry = 1'b1;
        cycle();
        cnt_carry = 1'b0;
        chk("carry_no_en", overflow, 1'b0);
        w = 0;
        while (!cnt_en && w < 10) begin
            cycle();
            w++;
        end
        chk("tick_wait", cnt_en, 1'b1);
        cnt_carry = 1'b1;
        cycle();
        cnt_carry = 1'b0;
        chk("ovf_set", overflow, 1'b1);
        btn_ss = 1'b1; cycle(); btn_ss = 1'b0;
        repeat (3) cycle();
        btn_ss = 1'b1; cycle(); btn_ss = 1'b0;
        cycle();
        chk("ovf_sticky", overflow, 1'b1);

        // Clear from PAUSED: one cycle of cnt_reset then IDLE
        btn_ss = 1'b1; cycle(); btn_ss = 1'b0;
        cycle();
        btn_lr = 1'b1;
        cycle();
        btn_lr = 1'b0;
        chk("clear_creset", cnt_reset, 1'b1);
        cycle();
        chk("clear_done",   cnt_reset, 1'b0);
        chk("clear_ovf",    overflow,  1'b0);
        chk("clear_idle",   running,   1'b0);

        // Simultaneous presses in RUN go to PAUSED
        btn_ss = 1'b1; cycle(); btn_ss = 1'b0;
        cycle(); cycle();
        btn_ss = 1'b1; btn_lr = 1'b1;
        cycle();
        btn_ss = 1'b0; btn_lr = 1'b0;
        chk("prio_running", running,    1'b0);
        chk("prio_lap",     lap_active, 1'b0);
        chk("prio_creset",  cnt_reset,  1'b0);
        cycle();

        // Mid-count reset
        btn_ss = 1'b1; cycle(); btn_ss = 1'b0;
        repeat (5) cycle();
        reset = 1'b1;
        cycle();
        chk("midrst_en",     cnt_en,    1'b0);
        chk("midrst_creset", cnt_reset, 1'b1);
        reset = 1'b0;
        cycle();
        chk("midrst_idle", running, 1'b0);

        // Randomized buttons, carry and occasional reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) btn_ss = ~btn_ss;
            if ($urandom_range(0, 6) == 0) btn_lr = ~btn_lr;
            cnt_carry = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 299) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control FSM that sequences the 3-digit BCD counter chain (mod-1000 counter with per-digit display registers and 7-segment decoders) as a stopwatch.
- Generates the chain's count enable, clear and display-load strobes from two push-button inputs and an internal tick prescaler.
- Supports start/stop, lap (display freeze while counting continues) and clear.
- Also tracks counter wrap-around via the chain's carry output.

Parameters:
- TICK_DIV, 10, clk cycles per count tick; legal range >= 2. Prescaler width is $clog2(TICK_DIV).

Ports:
- clk  input  1  system clock; all state updates on posedge clk.
- reset  input  1  synchronous reset, active-high.
- btn_start_stop  input  1  start/stop button level; already synchronised and debounced.
- btn_lap_reset  input  1  lap/clear button level; already synchronised and debounced.
- cnt_carry  input  1  carry out of the counter chain (high when count = 999 and enabled).
- cnt_en  output  1  count enable to the chain's least-significant digit; one-cycle tick pulse.
- cnt_reset  output  1  clear to the counter chain.
- cnt_load  output  1  load enable to the display registers.
- running  output  1  high in RUN or LAP.
- lap_active  output  1  high in LAP.
- overflow  output  1  sticky flag: counter has wrapped since the last clear.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE, prescaler = 0, overflow = 0.
  - Both button-history registers = 1, so a button held through reset release is not seen as a press.
  - While reset is high: cnt_reset = 1, cnt_en = 0, cnt_load = 1, running = 0, lap_active = 0.
- Press detection: a press is btn = 1 while its history register = 0. History updates every cycle. A press is acted on at the same clock edge it is sampled.
- States: IDLE, RUN, LAP, PAUSED, CLEAR. Transitions are evaluated at each posedge.
  - IDLE:
    - start_stop press -> RUN.
    - lap_reset press -> CLEAR.
  - RUN:
    - start_stop press -> PAUSED.
    - lap_reset press -> LAP.
  - LAP:
    - start_stop press -> PAUSED (display unfreezes and shows the stopped value).
    - lap_reset press -> RUN.
  - PAUSED:
    - start_stop press -> RUN.
    - lap_reset press -> CLEAR.
  - CLEAR: unconditionally -> IDLE after exactly one cycle; presses in CLEAR are ignored.
  - Simultaneous presses: start_stop has priority; lap_reset is discarded.
- Prescaler:
  - Counts 0..TICK_DIV-1 in RUN and LAP, wrapping to 0 after TICK_DIV-1.
  - Holds its value in PAUSED, so a resumed tick period continues where it stopped.
  - Forced to 0 in IDLE and CLEAR.
- Outputs (Moore, decoded from registered state and prescaler; no combinational path from the buttons):
  - cnt_en = (state in {RUN, LAP}) and (prescaler == TICK_DIV-1).
  - First tick is in the TICK_DIV-th cycle after entering RUN from IDLE, counting the entry cycle as cycle 0.
  - cnt_reset = reset or (state == CLEAR).
  - cnt_load = 1 in IDLE, RUN, PAUSED and CLEAR; 0 in LAP, which freezes the displayed digits while counting continues.
  - running = state in {RUN, LAP}.
  - lap_active = state == LAP.
- overflow:
  - Set at the posedge where cnt_carry = 1 and cnt_en = 1 (the chain wraps 999 -> 000).
  - Cleared only in CLEAR or reset.
  - Counting continues after the wrap; it does not stop at 999.
- cnt_carry while cnt_en = 0 is ignored.
- Reset asserted mid-count in any state returns to IDLE on that edge. No tick is issued in the reset cycle.

Decomposition:
- Package stopwatch_pkg:
  - typedef enum logic [2:0] sw_state_t {IDLE, RUN, LAP, PAUSED, CLEAR}.
  - Default TICK_DIV localparam.
- Sub-module btn_edge: history register plus rising-edge pulse, with history reset to 1. Instantiated twice.
- Prescaler and FSM stay in stopwatch_ctrl.

Test Plan:
- Reset then idle: reset high 2 cycles with btn_start_stop held 1, then released to 0; btn_start_stop kept 1 after reset -> no press detected, state IDLE, cnt_en = 0 throughout, cnt_reset = 1 only during reset.
- Start timing (TICK_DIV = 4): start press -> running = 1; cnt_en pulses in cycles 3, 7, 11 after RUN entry; after 40 cycles the model counter = 10.
- Pause/resume (TICK_DIV = 4): pause 2 cycles after a tick (prescaler = 1), hold 20 cycles, resume -> no cnt_en while paused; first tick after resume is 2 cycles later.
- Lap freeze: lap press in RUN -> cnt_load = 0 and lap_active = 1 while cnt_en keeps pulsing; second lap press -> cnt_load = 1 the next cycle.
- Clear and priority:
  - lap_reset press in PAUSED -> exactly one cycle of cnt_reset = 1, then IDLE, overflow = 0.
  - Both buttons pressed in the same cycle in RUN -> PAUSED.
- Overflow: drive cnt_carry = 1 coincident with a cnt_en pulse -> overflow = 1 from the next cycle; stays 1 through pause/resume until a clear.
